pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle program-counter sequencer for the processor's fetch stage. It fetches each instruction from instruction memory through a request/acknowledge handshake and presents it to decode/execute. It then consumes the branch unit's resolved `out` value together with the decoded instruction ID to compute the next PC. It also produces the link-register write for `jal`.

## Interface
- `PC_WIDTH`, 32, width of PC and memory address
- `RESET_PC`, 0, PC value loaded on reset
- `LINK_REG`, 31, register index written by `jal`
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin execution from current PC (sampled in IDLE only)
- `halt_req`  in  1  stop after the current instruction completes
- `imem_req`  out  1  instruction read request
- `imem_addr`  out  PC_WIDTH  read address (word address, equals PC)
- `imem_ack`  in  1  read data valid this cycle
- `imem_rdata`  in  32  instruction word
- `ir`  out  32  instruction register
- `ir_valid`  out  1  `ir` holds an instruction under decode/execute
- `exec_done`  in  1  execute stage finished; `instr_ID`/`br_out` valid this cycle
- `instr_ID`  in  32  decoded instruction ID
- `br_out`  in  32  branch unit output (offset or target)
- `pc`  out  PC_WIDTH  current PC
- `link_we`  out  1  register-file write strobe for link
- `link_addr`  out  5  = `LINK_REG`
- `link_data`  out  32  return address
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH, DECODE, UPDATE.
- IDLE:
  - all strobes low.
  - `start`=1 → FETCH.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`=1: `ir`<=`imem_rdata`, → DECODE.
  - Otherwise remain in FETCH with `imem_req` held high.
  - `imem_rdata` is ignored without ack.
- DECODE:
  - `ir_valid`=1.
  - On `exec_done`=1: latch `instr_ID` and `br_out` internally, → UPDATE.
  - Otherwise wait indefinitely.
- UPDATE:
  - `ir_valid`=0, `pc`<=next_pc.
  - Then → IDLE if `halt_req`=1 (sampled this cycle), else → FETCH.
- next_pc, using the latched values and PC_WIDTH-bit modulo arithmetic (wrap-around silent, no flag):
  - ID 15–20 (conditional): `pc`+1+`br_out`. `br_out`=0 when not taken, giving `pc`+1.
  - ID 21 `j`, 22 `jr`: `br_out` (absolute target).
  - ID 23 `jal`: `br_out`; additionally `link_we`=1 for the UPDATE cycle only, `link_data`=`pc`+1 (pre-update PC, zero-extended to 32).
  - Any other ID: `pc`+1.
- `br_out` is truncated to PC_WIDTH bits.
- `start` outside IDLE is ignored.
- `halt_req` outside UPDATE is ignored (not remembered).

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `ir`=0, `ir_valid`=0, `imem_req`=0, `link_we`=0, `link_data`=0, `busy`=0.
- Reset asserted in any state overrides everything on that edge. `imem_req` drops the following cycle; an in-flight ack is discarded.
- Minimum per-instruction latency is 3 cycles (FETCH, DECODE, UPDATE), with same-cycle ack and `exec_done`.
- Each cycle of ack delay adds one FETCH cycle. Each cycle of `exec_done` delay adds one DECODE cycle.
- Simultaneous events:
  - `imem_ack` and `reset` in the same cycle: `ir` stays 0.
  - `exec_done` in FETCH or IDLE: ignored.
  - `start` and `reset` in the same cycle: reset wins.
- `pc` changes only on the UPDATE→next edge or reset. `link_we` is never high outside UPDATE.

## Test plan
- Sequential: reset, `start`, memory acks immediately, IDs are non-branch (e.g. 1). Required: `imem_addr` 0,1,2,3 on FETCH cycles spaced 3 cycles apart, `busy`=1 throughout.
- `beq` at `pc`=5:
  - Taken, ID 15, `br_out`=10: next `imem_addr`=16.
  - Not taken, `br_out`=0: next `imem_addr`=6.
- `jal` at `pc`=7, ID 23, `br_out`=200: in UPDATE, `link_we`=1 for exactly 1 cycle, `link_addr`=31, `link_data`=8. Next fetch at 200. `j` with ID 21, `br_out`=100 → next fetch at 100, `link_we` stays 0.
- Wrap: `pc`=0xFFFFFFFF with a non-branch instruction → `pc`=0. With `pc`=0xFFFFFFFE, ID 16, `br_out`=3 → `pc`=2.
- Handshake stalls: ack delayed 3 cycles gives `imem_req` high for 4 cycles with `ir` unchanged until ack. `exec_done` delayed 2 cycles gives `ir_valid` high for 3 cycles. `halt_req` asserted in UPDATE → IDLE, `busy`=0, no further `imem_req`.
- Reset mid-operation: assert `reset` in FETCH while ack arrives, and separately in DECODE. Required: next cycle state IDLE, `pc`=`RESET_PC`, `ir`=0, all strobes 0, and a fresh `start` resumes fetching from `RESET_PC`.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: fetches through a req/ack handshake,
// waits for execute, then computes the next PC and the jal link write.
module pc_sequencer #(
  parameter int unsigned         PC_WIDTH = 32'd32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}},
  parameter int unsigned         LINK_REG = 32'd31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         ir,
  output logic                ir_valid,
  input  logic                exec_done,
  input  logic [31:0]         instr_ID,
  input  logic [31:0]         br_out,
  output logic [PC_WIDTH-1:0] pc,
  output logic                link_we,
  output logic [4:0]          link_addr,
  output logic [31:0]         link_data,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  localparam logic [31:0]         ID_COND_LO = 32'd15;
  localparam logic [31:0]         ID_COND_HI = 32'd20;
  localparam logic [31:0]         ID_J       = 32'd21;
  localparam logic [31:0]         ID_JR      = 32'd22;
  localparam logic [31:0]         ID_JAL     = 32'd23;
  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1'b1);

  state_t              state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [31:0]         ir_r;
  logic                ir_valid_r;
  logic                imem_req_r;
  logic                link_we_r;
  logic [31:0]         link_data_r;
  logic                busy_r;
  logic [31:0]         id_r;
  logic [31:0]         br_r;
  logic [PC_WIDTH-1:0] br_tgt_s;
  logic [PC_WIDTH-1:0] next_pc_s;

  // br_out is cut (or zero-extended) to PC width; all PC arithmetic wraps silently
  assign br_tgt_s = PC_WIDTH'(br_r);

  // Next-PC selection from the instruction ID and branch result latched in DECODE
  always_comb begin
    next_pc_s = pc_r + PC_ONE;
    if ((id_r >= ID_COND_LO) && (id_r <= ID_COND_HI)) begin
      next_pc_s = pc_r + PC_ONE + br_tgt_s;
    end else if ((id_r == ID_J) || (id_r == ID_JR) || (id_r == ID_JAL)) begin
      next_pc_s = br_tgt_s;
    end else begin
      next_pc_s = pc_r + PC_ONE;
    end
  end

  // Sequencer FSM; strobes are registered so they are set on the edge entering their state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC;
      ir_r        <= 32'd0;
      ir_valid_r  <= 1'b0;
      imem_req_r  <= 1'b0;
      link_we_r   <= 1'b0;
      link_data_r <= 32'd0;
      busy_r      <= 1'b0;
      id_r        <= 32'd0;
      br_r        <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r    <= S_FETCH;
            imem_req_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_r    <= S_DECODE;
            ir_r       <= imem_rdata;
            imem_req_r <= 1'b0;
            ir_valid_r <= 1'b1;
          end
        end
        S_DECODE: begin
          if (exec_done) begin
            state_r    <= S_UPDATE;
            id_r       <= instr_ID;
            br_r       <= br_out;
            ir_valid_r <= 1'b0;
            link_we_r  <= (instr_ID == ID_JAL);
            if (instr_ID == ID_JAL) begin
              link_data_r <= 32'(pc_r + PC_ONE);
            end
          end
        end
        S_UPDATE: begin
          pc_r      <= next_pc_s;
          link_we_r <= 1'b0;
          if (halt_req) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r    <= S_FETCH;
            imem_req_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          ir_valid_r <= 1'b0;
          imem_req_r <= 1'b0;
          link_we_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign ir        = ir_r;
  assign ir_valid  = ir_valid_r;
  assign pc        = pc_r;
  assign link_we   = link_we_r;
  assign link_addr = 5'(LINK_REG);
  assign link_data = link_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: sequential flow, branches,
// jal link write, wrap-around, handshake stalls, halt and mid-operation reset.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        exec_done;
  logic [31:0] instr_ID;
  logic [31:0] br_out;
  logic [31:0] pc;
  logic        link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic        busy;

  int          vec_cnt;
  int          err_cnt;
  logic [31:0] last_word;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt_req   (halt_req),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .exec_done  (exec_done),
    .instr_ID   (instr_ID),
    .br_out     (br_out),
    .pc         (pc),
    .link_we    (link_we),
    .link_addr  (link_addr),
    .link_data  (link_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt = vec_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_link_we", link_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
  endtask

  // Entered right after the edge into FETCH; leaves right after the UPDATE edge.
  task automatic do_instr(input logic [31:0] cur, input logic [31:0] id,
                          input logic [31:0] bo, input int ack_dly,
                          input int done_dly, input logic halt,
                          input logic [31:0] nxt);
    logic [31:0] word;
    word = 32'hC0DE_0000 ^ cur;
    chk("fetch_addr", imem_addr, cur);
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_busy", busy, 1'b1);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      chk("stall_req", imem_req, 1'b1);
      chk("stall_ir", ir, last_word);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    last_word  = word;
    chk("decode_ir", ir, word);
    chk("decode_ir_valid", ir_valid, 1'b1);
    chk("decode_req", imem_req, 1'b0);
    chk("decode_busy", busy, 1'b1);
    for (int i = 0; i < done_dly; i++) begin
      exec_done = 1'b0;
      halt_req  = 1'b1;
      tick();
      chk("wait_ir_valid", ir_valid, 1'b1);
      chk("wait_link_we", link_we, 1'b0);
    end
    exec_done = 1'b1;
    instr_ID  = id;
    br_out    = bo;
    halt_req  = 1'b1;
    tick();
    exec_done = 1'b0;
    instr_ID  = 32'd0;
    br_out    = 32'd0;
    chk("upd_ir_valid", ir_valid, 1'b0);
    chk("upd_link_we", link_we, (id == 32'd23));
    chk("upd_link_addr", link_addr, 5'd31);
    chk("upd_pc_hold", pc, cur);
    chk("upd_busy", busy, 1'b1);
    if (id == 32'd23) begin
      chk("upd_link_data", link_data, cur + 32'd1);
    end
    halt_req = halt;
    tick();
    halt_req = 1'b0;
    chk("next_pc", pc, nxt);
    chk("post_link_we", link_we, 1'b0);
    chk("post_req", imem_req, !halt);
    chk("post_busy", busy, !halt);
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    last_word  = 32'd0;
    reset      = 1'b1;
    start      = 1'b0;
    halt_req   = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    exec_done  = 1'b0;
    instr_ID   = 32'd0;
    br_out     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check_idle_reset();
    chk("rst_link_data", link_data, 32'd0);

    // exec_done while idle must not wake the sequencer
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("idle_ignore_req", imem_req, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    do_instr(32'd0, 32'd1, 32'd0, 0, 0, 1'b0, 32'd1);
    do_instr(32'd1, 32'd1, 32'd0, 0, 0, 1'b0, 32'd2);
    do_instr(32'd2, 32'd1, 32'd0, 0, 0, 1'b0, 32'd3);
    do_instr(32'd3, 32'd1, 32'd0, 0, 0, 1'b0, 32'd4);
    do_instr(32'd4, 32'd1, 32'd0, 0, 0, 1'b0, 32'd5);
    do_instr(32'd5, 32'd15, 32'd10, 0, 0, 1'b0, 32'd16);
    do_instr(32'd16, 32'd21, 32'd5, 0, 0, 1'b0, 32'd5);
    do_instr(32'd5, 32'd15, 32'd0, 0, 0, 1'b0, 32'd6);
    do_instr(32'd6, 32'd22, 32'd7, 0, 0, 1'b0, 32'd7);
    do_instr(32'd7, 32'd23, 32'd200, 0, 0, 1'b0, 32'd200);
    do_instr(32'd200, 32'd21, 32'd100, 0, 0, 1'b0, 32'd100);
    do_instr(32'd100, 32'd21, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'hFFFF_FFFF);
    do_instr(32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1'b0, 32'd0);
    do_instr(32'd0, 32'd21, 32'hFFFF_FFFE, 0, 0, 1'b0, 32'hFFFF_FFFE);
    do_instr(32'hFFFF_FFFE, 32'd16, 32'd3, 0, 0, 1'b0, 32'd2);
    do_instr(32'd2, 32'd1, 32'd0, 3, 0, 1'b0, 32'd3);
    do_instr(32'd3, 32'd1, 32'd0, 0, 2, 1'b1, 32'd4);

    tick();
    chk("halt_idle_req", imem_req, 1'b0);
    chk("halt_idle_busy", busy, 1'b0);
    chk("halt_idle_pc", pc, 32'd4);

    // reset in FETCH with ack and start on the same edge
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("refetch_addr", imem_addr, 32'd4);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    reset      = 1'b1;
    start      = 1'b1;
    tick();
    reset    = 1'b0;
    start    = 1'b0;
    imem_ack = 1'b0;
    check_idle_reset();
    tick();
    chk("post_rst_req", imem_req, 1'b0);

    // reset while in DECODE
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_addr", imem_addr, 32'd0);
    chk("resume_req", imem_req, 1'b1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    tick();
    imem_ack = 1'b0;
    chk("dec_ir_valid", ir_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_reset();
    last_word = 32'd0;

    start = 1'b1;
    tick();
    start = 1'b0;
    do_instr(32'd0, 32'd1, 32'd0, 0, 0, 1'b1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
